// File: rtl/mem_stage_lsu.sv
// Memory stage load/store unit: registers one EX op, drives the data SRAM,
// forwards store data from writeback sources, flags misaligned accesses and
// extends load data before handing the result to WB.
module mem_stage_lsu #(
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5,
    parameter int FWD_N  = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_load,
    input  logic                    in_store,
    input  logic [1:0]              in_size,
    input  logic                    in_unsigned,
    input  logic [ADDR_W-1:0]       in_addr,
    input  logic [31:0]             in_alu_result,
    input  logic [REG_W-1:0]        in_rt,
    input  logic [31:0]             in_rt_data,
    input  logic [REG_W-1:0]        in_dest,
    input  logic                    in_wen,
    input  logic [FWD_N-1:0]        fwd_wen,
    input  logic [FWD_N*REG_W-1:0]  fwd_dest,
    input  logic [FWD_N*32-1:0]     fwd_data,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [ADDR_W-1:0]       data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    input  logic [31:0]             data_sram_rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_result,
    output logic [REG_W-1:0]        out_dest,
    output logic                    out_wen,
    output logic                    out_exc,
    output logic                    out_exc_store,
    output logic [ADDR_W-1:0]       out_badvaddr
);

    typedef enum logic [1:0] {EMPTY, ACCESS, LWAIT, HOLD} state_t;

    state_t              state;
    state_t              state_next;

    logic                op_load;
    logic                op_store;
    logic [1:0]          op_size;
    logic                op_unsigned;
    logic [ADDR_W-1:0]   op_addr;
    logic [REG_W-1:0]    op_rt;
    logic [31:0]         op_rt_data;
    logic [REG_W-1:0]    op_dest;
    logic                op_wen;
    logic [31:0]         result_q;

    logic                accept;
    logic                op_mem;
    logic                misaligned;
    logic                fwd_hit;
    logic [31:0]         store_data;
    logic [3:0]          lane_wen;
    logic [31:0]         lane_wdata;
    logic [7:0]          byte_lane;
    logic [15:0]         half_lane;
    logic [31:0]         load_value;

    assign in_ready = resetn & ((state == EMPTY) | ((state == HOLD) & out_ready));
    assign accept   = in_valid & in_ready;
    assign op_mem   = op_load | op_store;

    // State register; reset drops any in-flight op immediately
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= EMPTY;
        else         state <= state_next;
    end

    // Capture the accepted op, then overwrite the result with load data
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_load     <= 1'b0;
            op_store    <= 1'b0;
            op_size     <= 2'd0;
            op_unsigned <= 1'b0;
            op_addr     <= '0;
            op_rt       <= '0;
            op_rt_data  <= '0;
            op_dest     <= '0;
            op_wen      <= 1'b0;
            result_q    <= '0;
        end else if (accept) begin
            op_load     <= in_load;
            op_store    <= in_store;
            op_size     <= in_size;
            op_unsigned <= in_unsigned;
            op_addr     <= in_addr;
            op_rt       <= in_rt;
            op_rt_data  <= in_rt_data;
            op_dest     <= in_dest;
            op_wen      <= in_wen;
            result_q    <= in_alu_result;
        end else if (state == LWAIT) begin
            result_q    <= load_value;
        end
    end

    // Alignment check: halves need an even address, words (size 2 or 3) a multiple of four
    always_comb begin
        misaligned = 1'b0;
        case (op_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = op_addr[0];
            default: misaligned = (op_addr[1:0] != 2'b00);
        endcase
    end

    // Store data: lowest-index matching writeback source wins, register zero never forwards
    always_comb begin
        store_data = op_rt_data;
        fwd_hit    = 1'b0;
        for (int i = 0; i < FWD_N; i++) begin
            if (!fwd_hit && fwd_wen[i] &&
                (fwd_dest[i*REG_W +: REG_W] != '0) &&
                (fwd_dest[i*REG_W +: REG_W] == op_rt)) begin
                store_data = fwd_data[i*32 +: 32];
                fwd_hit    = 1'b1;
            end
        end
    end

    // Byte-lane enables and lane-replicated write data for the store size
    always_comb begin
        lane_wen   = 4'b1111;
        lane_wdata = store_data;
        case (op_size)
            2'd0: begin
                lane_wen   = 4'b0001 << op_addr[1:0];
                lane_wdata = {4{store_data[7:0]}};
            end
            2'd1: begin
                lane_wen   = 4'b0011 << op_addr[1:0];
                lane_wdata = {2{store_data[15:0]}};
            end
            default: begin
                lane_wen   = 4'b1111;
                lane_wdata = store_data;
            end
        endcase
    end

    // Pick the addressed lane of the returned word and sign- or zero-extend it
    always_comb begin
        byte_lane  = data_sram_rdata[{op_addr[1:0], 3'b000} +: 8];
        half_lane  = op_addr[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
        load_value = data_sram_rdata;
        case (op_size)
            2'd0:    load_value = {{24{~op_unsigned & byte_lane[7]}}, byte_lane};
            2'd1:    load_value = {{16{~op_unsigned & half_lane[15]}}, half_lane};
            default: load_value = data_sram_rdata;
        endcase
    end

    // Next-state sequencing plus SRAM request and WB-facing outputs
    always_comb begin
        state_next      = state;
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'b0000;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
        out_valid       = 1'b0;
        out_result      = '0;
        out_dest        = '0;
        out_wen         = 1'b0;
        out_exc         = 1'b0;
        out_exc_store   = 1'b0;
        out_badvaddr    = '0;
        case (state)
            EMPTY: begin
                if (accept) state_next = (in_load | in_store) ? ACCESS : HOLD;
            end
            ACCESS: begin
                if (misaligned) begin
                    state_next = HOLD;
                end else begin
                    data_sram_en    = 1'b1;
                    data_sram_addr  = {op_addr[ADDR_W-1:2], 2'b00};
                    data_sram_wen   = op_store ? lane_wen : 4'b0000;
                    data_sram_wdata = op_store ? lane_wdata : 32'd0;
                    state_next      = op_store ? HOLD : LWAIT;
                end
            end
            LWAIT: begin
                state_next = HOLD;
            end
            HOLD: begin
                out_valid     = 1'b1;
                out_result    = result_q;
                out_dest      = op_dest;
                out_exc       = op_mem & misaligned;
                out_exc_store = op_mem & misaligned & op_store;
                out_badvaddr  = (op_mem & misaligned) ? op_addr : '0;
                out_wen       = op_wen & ~op_store & ~(op_mem & misaligned);
                if (out_ready) begin
                    if (accept) state_next = (in_load | in_store) ? ACCESS : HOLD;
                    else        state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus randomized
// ops compared against a behavioural model of the memory stage.
module tb_mem_stage_lsu;

    localparam int ADDR_W = 32;
    localparam int REG_W  = 5;
    localparam int FWD_N  = 2;

    logic                   clk;
    logic                   resetn;
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_load;
    logic                   in_store;
    logic [1:0]             in_size;
    logic                   in_unsigned;
    logic [ADDR_W-1:0]      in_addr;
    logic [31:0]            in_alu_result;
    logic [REG_W-1:0]       in_rt;
    logic [31:0]            in_rt_data;
    logic [REG_W-1:0]       in_dest;
    logic                   in_wen;
    logic [FWD_N-1:0]       fwd_wen;
    logic [FWD_N*REG_W-1:0] fwd_dest;
    logic [FWD_N*32-1:0]    fwd_data;
    logic                   data_sram_en;
    logic [3:0]             data_sram_wen;
    logic [ADDR_W-1:0]      data_sram_addr;
    logic [31:0]            data_sram_wdata;
    logic [31:0]            data_sram_rdata;
    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            out_result;
    logic [REG_W-1:0]       out_dest;
    logic                   out_wen;
    logic                   out_exc;
    logic                   out_exc_store;
    logic [ADDR_W-1:0]      out_badvaddr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic                load;
        logic                store;
        logic [1:0]          size;
        logic                uns;
        logic [ADDR_W-1:0]   addr;
        logic [31:0]         alu;
        logic [REG_W-1:0]    rt;
        logic [31:0]         rt_data;
        logic [REG_W-1:0]    dest;
        logic                wen;
        logic [FWD_N-1:0]    fwen;
        logic [FWD_N*REG_W-1:0] fdest;
        logic [FWD_N*32-1:0] fdata;
        logic [31:0]         rdata;
    } op_t;

    typedef struct {
        int                lat;
        int                en_cycles;
        int                stray;
        int                busy_ready;
        logic              ready_issue;
        logic              after_valid;
        logic [ADDR_W-1:0] sram_addr;
        logic [3:0]        sram_wen;
        logic [31:0]       sram_wdata;
        logic [31:0]       result;
        logic [REG_W-1:0]  dest;
        logic              wen;
        logic              exc;
        logic              exc_store;
        logic [ADDR_W-1:0] badvaddr;
    } obs_t;

    mem_stage_lsu #(.ADDR_W(ADDR_W), .REG_W(REG_W), .FWD_N(FWD_N)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_load(in_load), .in_store(in_store), .in_size(in_size),
        .in_unsigned(in_unsigned), .in_addr(in_addr), .in_alu_result(in_alu_result),
        .in_rt(in_rt), .in_rt_data(in_rt_data), .in_dest(in_dest), .in_wen(in_wen),
        .fwd_wen(fwd_wen), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_dest(out_dest), .out_wen(out_wen), .out_exc(out_exc),
        .out_exc_store(out_exc_store), .out_badvaddr(out_badvaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic op_t blank_op();
        op_t o;
        o = '{default: '0};
        return o;
    endfunction

    // Reference model: what WB and the SRAM should see for one isolated op
    function automatic obs_t model(op_t op);
        obs_t e;
        int   sz, nb, a;
        logic mem, mis;
        logic [31:0] sd, v, mask;
        e   = '{default: 0};
        mem = op.load | op.store;
        sz  = (op.size == 2'd3) ? 2 : int'(op.size);
        nb  = 1 << sz;
        a   = int'(op.addr[1:0]);
        mis = mem && ((a % nb) != 0);
        e.lat         = !mem ? 1 : (mis ? 2 : (op.store ? 2 : 3));
        e.en_cycles   = (mem && !mis) ? 1 : 0;
        e.ready_issue = 1'b1;
        e.sram_addr   = op.addr & ~32'h3;
        e.sram_wen    = op.store ? 4'(((1 << nb) - 1) << a) : 4'd0;
        sd = op.rt_data;
        for (int i = 0; i < FWD_N; i++) begin
            if (op.fwen[i] && op.fdest[i*REG_W +: REG_W] != 0 && op.fdest[i*REG_W +: REG_W] == op.rt) begin
                sd = op.fdata[i*32 +: 32];
                break;
            end
        end
        if (!op.store)    e.sram_wdata = 32'd0;
        else if (nb == 1) e.sram_wdata = sd[7:0] * 32'h01010101;
        else if (nb == 2) e.sram_wdata = sd[15:0] * 32'h00010001;
        else              e.sram_wdata = sd;
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        v    = (op.rdata >> (8 * a)) & mask;
        if (!op.uns && nb < 4 && v[8*nb-1]) v = v | ~mask;
        e.result    = (op.load && !mis) ? v : op.alu;
        e.dest      = op.dest;
        e.wen       = !op.store && !mis && op.wen;
        e.exc       = mis;
        e.exc_store = mis && op.store;
        e.badvaddr  = op.addr;
        return e;
    endfunction

    // Issue one op from EMPTY, track it to WB with a cycle budget, then drain it
    task automatic do_op(input op_t op, output obs_t o);
        o = '{default: 0};
        in_load = op.load;  in_store = op.store; in_size = op.size; in_unsigned = op.uns;
        in_addr = op.addr;  in_alu_result = op.alu; in_rt = op.rt; in_rt_data = op.rt_data;
        in_dest = op.dest;  in_wen = op.wen;
        fwd_wen = op.fwen;  fwd_dest = op.fdest; fwd_data = op.fdata;
        data_sram_rdata = op.rdata;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        @(negedge clk);
        o.ready_issue = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (data_sram_en) begin
                o.en_cycles++;
                o.sram_addr  = data_sram_addr;
                o.sram_wen   = data_sram_wen;
                o.sram_wdata = data_sram_wdata;
            end else if (data_sram_wen != 0 || data_sram_addr != 0 || data_sram_wdata != 0) begin
                o.stray++;
            end
            if (out_valid) begin
                o.lat = n; o.result = out_result; o.dest = out_dest; o.wen = out_wen;
                o.exc = out_exc; o.exc_store = out_exc_store; o.badvaddr = out_badvaddr;
                break;
            end
            if (in_ready) o.busy_ready++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        o.after_valid = out_valid;
        @(posedge clk); #1;
    endtask

    // Outputs are quiet under reset and the stage accepts once released
    task automatic test_reset();
        resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_load = 0; in_store = 0; in_size = 0; in_unsigned = 0; in_addr = 0;
        in_alu_result = 0; in_rt = 0; in_rt_data = 0; in_dest = 0; in_wen = 0;
        fwd_wen = 0; fwd_dest = 0; fwd_data = 0; data_sram_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset out_valid: got %b expected 0", out_valid); end
        total++; if (data_sram_en !== 1'b0) begin bad++; $display("[TB] FAIL reset sram_en: got %b expected 0", data_sram_en); end
        total++; if (out_result !== 32'd0) begin bad++; $display("[TB] FAIL reset out_result: got %h expected 0", out_result); end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset in_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
    endtask

    // Non-memory op passes its ALU result through with no SRAM activity
    task automatic test_alu();
        op_t op; obs_t o;
        op = blank_op(); op.alu = 32'h1234; op.dest = 5'd3; op.wen = 1'b1;
        do_op(op, o);
        total++; if (o.lat !== 1) begin bad++; $display("[TB] FAIL alu latency: got %0d expected 1", o.lat); end
        total++; if (o.result !== 32'h1234) begin bad++; $display("[TB] FAIL alu result: got %h expected 00001234", o.result); end
        total++; if (o.dest !== 5'd3) begin bad++; $display("[TB] FAIL alu dest: got %0d expected 3", o.dest); end
        total++; if (o.wen !== 1'b1) begin bad++; $display("[TB] FAIL alu wen: got %b expected 1", o.wen); end
        total++; if (o.en_cycles !== 0) begin bad++; $display("[TB] FAIL alu sram_en cycles: got %0d expected 0", o.en_cycles); end
    endtask

    // Byte store to the top lane of a word
    task automatic test_store_byte();
        op_t op; obs_t o;
        op = blank_op(); op.store = 1'b1; op.size = 2'd0; op.addr = 32'h1003;
        op.rt = 5'd6; op.rt_data = 32'h0000_00AB; op.wen = 1'b1;
        do_op(op, o);
        total++; if (o.en_cycles !== 1) begin bad++; $display("[TB] FAIL stb en cycles: got %0d expected 1", o.en_cycles); end
        total++; if (o.sram_addr !== 32'h1000) begin bad++; $display("[TB] FAIL stb addr: got %h expected 00001000", o.sram_addr); end
        total++; if (o.sram_wen !== 4'b1000) begin bad++; $display("[TB] FAIL stb wen: got %b expected 1000", o.sram_wen); end
        total++; if (o.sram_wdata !== 32'hABAB_ABAB) begin bad++; $display("[TB] FAIL stb wdata: got %h expected ababab ab", o.sram_wdata); end
        total++; if (o.wen !== 1'b0) begin bad++; $display("[TB] FAIL stb out_wen: got %b expected 0", o.wen); end
        total++; if (o.lat !== 2) begin bad++; $display("[TB] FAIL stb latency: got %0d expected 2", o.lat); end
    endtask

    // Forwarding priority and the never-forward-from-zero rule
    task automatic test_forwarding();
        op_t op; obs_t o;
        op = blank_op(); op.store = 1'b1; op.size = 2'd2; op.addr = 32'h100;
        op.rt = 5'd5; op.rt_data = 32'hDEAD_BEEF;
        op.fdest = {5'd5, 5'd5}; op.fdata = {32'h22, 32'h11}; op.fwen = 2'b11;
        do_op(op, o);
        total++; if (o.sram_wdata !== 32'h11) begin bad++; $display("[TB] FAIL fwd both: got %h expected 00000011", o.sram_wdata); end
        op.fwen = 2'b10;
        do_op(op, o);
        total++; if (o.sram_wdata !== 32'h22) begin bad++; $display("[TB] FAIL fwd src1: got %h expected 00000022", o.sram_wdata); end
        op.rt = 5'd0; op.fdest = '0; op.fwen = 2'b11;
        do_op(op, o);
        total++; if (o.sram_wdata !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL fwd rt0: got %h expected deadbeef", o.sram_wdata); end
    endtask

    // Upper-half load, signed then unsigned
    task automatic test_load_half();
        op_t op; obs_t o;
        op = blank_op(); op.load = 1'b1; op.size = 2'd1; op.addr = 32'h2002;
        op.rdata = 32'h80FF_1234; op.dest = 5'd4; op.wen = 1'b1;
        do_op(op, o);
        total++; if (o.result !== 32'hFFFF_80FF) begin bad++; $display("[TB] FAIL lh signed: got %h expected ffff80ff", o.result); end
        total++; if (o.lat !== 3) begin bad++; $display("[TB] FAIL lh latency: got %0d expected 3", o.lat); end
        total++; if (o.sram_wen !== 4'b0000) begin bad++; $display("[TB] FAIL lh sram wen: got %b expected 0000", o.sram_wen); end
        op.uns = 1'b1;
        do_op(op, o);
        total++; if (o.result !== 32'h0000_80FF) begin bad++; $display("[TB] FAIL lhu: got %h expected 000080ff", o.result); end
        total++; if (o.wen !== 1'b1) begin bad++; $display("[TB] FAIL lhu wen: got %b expected 1", o.wen); end
    endtask

    // Misaligned word load and half store raise address errors without touching the SRAM
    task automatic test_misaligned();
        op_t op; obs_t o;
        op = blank_op(); op.load = 1'b1; op.size = 2'd2; op.addr = 32'h3001; op.wen = 1'b1; op.dest = 5'd8;
        do_op(op, o);
        total++; if (o.en_cycles !== 0) begin bad++; $display("[TB] FAIL mis lw en: got %0d expected 0", o.en_cycles); end
        total++; if (o.exc !== 1'b1) begin bad++; $display("[TB] FAIL mis lw exc: got %b expected 1", o.exc); end
        total++; if (o.exc_store !== 1'b0) begin bad++; $display("[TB] FAIL mis lw exc_store: got %b expected 0", o.exc_store); end
        total++; if (o.badvaddr !== 32'h3001) begin bad++; $display("[TB] FAIL mis lw badvaddr: got %h expected 00003001", o.badvaddr); end
        total++; if (o.wen !== 1'b0) begin bad++; $display("[TB] FAIL mis lw wen: got %b expected 0", o.wen); end
        total++; if (o.lat !== 2) begin bad++; $display("[TB] FAIL mis lw latency: got %0d expected 2", o.lat); end
        op.load = 1'b0; op.store = 1'b1; op.size = 2'd1;
        do_op(op, o);
        total++; if (o.exc_store !== 1'b1) begin bad++; $display("[TB] FAIL mis sh exc_store: got %b expected 1", o.exc_store); end
        total++; if (o.en_cycles !== 0) begin bad++; $display("[TB] FAIL mis sh en: got %0d expected 0", o.en_cycles); end
    endtask

    // WB stalls with a new op pending, then both handshakes complete on one edge
    task automatic test_back_to_back();
        in_load = 0; in_store = 0; in_size = 0; in_alu_result = 32'hA5A5; in_dest = 5'd7; in_wen = 1'b1;
        out_ready = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_alu_result = 32'h5A5A; in_dest = 5'd9;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b stall%0d valid: got %b expected 1", k, out_valid); end
            total++; if (out_result !== 32'hA5A5) begin bad++; $display("[TB] FAIL b2b stall%0d result: got %h expected 0000a5a5", k, out_result); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL b2b stall%0d in_ready: got %b expected 0", k, in_ready); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b release in_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b second valid: got %b expected 1", out_valid); end
        total++; if (out_result !== 32'h5A5A) begin bad++; $display("[TB] FAIL b2b second result: got %h expected 00005a5a", out_result); end
        total++; if (out_dest !== 5'd9) begin bad++; $display("[TB] FAIL b2b second dest: got %0d expected 9", out_dest); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b drained: got %b expected 0", out_valid); end
        @(posedge clk); #1;
    endtask

    // Reset pulled during an SRAM access kills the request at once and drops the op
    task automatic test_reset_mid_access();
        in_load = 1'b1; in_store = 1'b0; in_size = 2'd2; in_addr = 32'h40;
        in_dest = 5'd2; in_wen = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (data_sram_en !== 1'b1) begin bad++; $display("[TB] FAIL rst_mid pre en: got %b expected 1", data_sram_en); end
        #1 resetn = 1'b0;
        #1;
        total++; if (data_sram_en !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid async en: got %b expected 0", data_sram_en); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid out_valid: got %b expected 0", out_valid); end
        @(posedge clk); #1;
        resetn = 1'b1; in_load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid dropped%0d: got %b expected 0", k, out_valid); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_mid in_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
    endtask

    // Randomized ops of every kind, size and alignment against the model
    task automatic test_random();
        op_t op; obs_t o, e; int r;
        for (int k = 0; k < 200; k++) begin
            op = blank_op();
            r = $urandom_range(0, 2);
            op.load = (r == 1); op.store = (r == 2);
            op.size = 2'($urandom_range(0, 3)); op.uns = 1'($urandom);
            op.addr = $urandom; op.alu = $urandom; op.rt = 5'($urandom_range(0, 7));
            op.rt_data = $urandom; op.dest = 5'($urandom); op.wen = 1'($urandom);
            op.fwen = 2'($urandom); op.rdata = $urandom;
            op.fdata = {32'($urandom), 32'($urandom)};
            for (int i = 0; i < FWD_N; i++) begin
                r = $urandom_range(0, 2);
                op.fdest[i*REG_W +: REG_W] = (r == 0) ? 5'd0 : ((r == 1) ? op.rt : 5'($urandom));
            end
            e = model(op);
            do_op(op, o);
            total++; if (o.lat !== e.lat) begin bad++; $display("[TB] FAIL rand%0d latency: got %0d expected %0d", k, o.lat, e.lat); end
            total++; if (o.ready_issue !== 1'b1) begin bad++; $display("[TB] FAIL rand%0d ready_issue: got %b expected 1", k, o.ready_issue); end
            total++; if (o.busy_ready !== 0) begin bad++; $display("[TB] FAIL rand%0d busy in_ready: got %0d expected 0", k, o.busy_ready); end
            total++; if (o.stray !== 0) begin bad++; $display("[TB] FAIL rand%0d idle sram: got %0d expected 0", k, o.stray); end
            total++; if (o.after_valid !== 1'b0) begin bad++; $display("[TB] FAIL rand%0d drain: got %b expected 0", k, o.after_valid); end
            total++; if (o.en_cycles !== e.en_cycles) begin bad++; $display("[TB] FAIL rand%0d en cycles: got %0d expected %0d", k, o.en_cycles, e.en_cycles); end
            if (e.en_cycles == 1) begin
                total++; if (o.sram_addr !== e.sram_addr) begin bad++; $display("[TB] FAIL rand%0d sram addr: got %h expected %h", k, o.sram_addr, e.sram_addr); end
                total++; if (o.sram_wen !== e.sram_wen) begin bad++; $display("[TB] FAIL rand%0d sram wen: got %b expected %b", k, o.sram_wen, e.sram_wen); end
                total++; if (o.sram_wdata !== e.sram_wdata) begin bad++; $display("[TB] FAIL rand%0d sram wdata: got %h expected %h", k, o.sram_wdata, e.sram_wdata); end
            end
            total++; if (o.dest !== e.dest) begin bad++; $display("[TB] FAIL rand%0d dest: got %0d expected %0d", k, o.dest, e.dest); end
            total++; if (o.wen !== e.wen) begin bad++; $display("[TB] FAIL rand%0d out_wen: got %b expected %b", k, o.wen, e.wen); end
            total++; if (o.exc !== e.exc) begin bad++; $display("[TB] FAIL rand%0d exc: got %b expected %b", k, o.exc, e.exc); end
            total++; if (o.exc_store !== e.exc_store) begin bad++; $display("[TB] FAIL rand%0d exc_store: got %b expected %b", k, o.exc_store, e.exc_store); end
            if (e.exc) begin
                total++; if (o.badvaddr !== e.badvaddr) begin bad++; $display("[TB] FAIL rand%0d badvaddr: got %h expected %h", k, o.badvaddr, e.badvaddr); end
            end else if (!op.store) begin
                total++; if (o.result !== e.result) begin bad++; $display("[TB] FAIL rand%0d result: got %h expected %h", k, o.result, e.result); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store_byte();
        test_forwarding();
        test_load_half();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
